ex_muldiv_unit: RTL and testbench

- Iterative RV32M/RV64M multiply/divide unit in the execute stage, parallel to the single-cycle ALU and branch unit.
- Accepts one operation at a time over a valid/ready request handshake and returns result plus destination register over a valid/ready response handshake.
- Parametrised in data width and multiplier bits retired per cycle.
- Drives busy_o so the pipeline controller can stall younger instructions. flush_i aborts in-flight work on branch mispredict.

---
 rtl/ex_muldiv_unit.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Iterative RV32M/RV64M multiply/divide unit that sits in the execute stage
// next to the single-cycle ALU. One operation is in flight at a time.
//
// Multiplies use a 2*XLEN shift-add accumulator that retires
// MUL_BITS_PER_CYCLE multiplier bits per CALC cycle. Divides use a radix-2
// restoring divider that retires one quotient bit per cycle. Both work on
// operand magnitudes, and the result sign is applied when the result is
// written into the output register.
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN - a multiply leaves CALC as soon as the remaining
//                         multiplier bits are all zero (a zero multiplier
//                         goes straight to DONE). Divide timing is unchanged.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush_i          abort the in-flight op and drop its response
//   req_valid_i      request valid        req_ready_o   unit can accept
//   op_i             funct3 (MUL..REMU)   rs1_i, rs2_i  operands
//   rd_i             destination tag
//   resp_valid_o     result valid         resp_ready_i  consumer takes it
//   result_o, rd_o   result and its tag
//   busy_o           high in CALC or DONE
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int XLEN               = 32,
  parameter int MUL_BITS_PER_CYCLE = 4,
  parameter int RD_W               = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [RD_W-1:0] rd_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [RD_W-1:0] rd_o,
  output logic            busy_o
);

  localparam int K_MUL = XLEN / MUL_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(K_MUL - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  // Conditional two's-complement negation, operand width and product width.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v,
                                                   input logic              neg);
    return neg ? -v : v;
  endfunction

  // -------------------------------------------------------------------------
  // State
  //   Multiply: acc = partial product, mcand = shifted multiplicand,
  //             mplier = unprocessed multiplier bits (shifted right).
  //   Divide:   acc[XLEN-1:0] = partial remainder, mplier = dividend bits
  //             shifting out while quotient bits shift in,
  //             mcand[XLEN-1:0] = divisor magnitude.
  // -------------------------------------------------------------------------
  logic [1:0]        state_q,  state_d;
  logic [2:0]        op_q,     op_d;
  logic [RD_W-1:0]   rd_q,     rd_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [2*XLEN-1:0] acc_q,    acc_d;
  logic [2*XLEN-1:0] mcand_q,  mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              neg_q,    neg_d;   // negate product / quotient
  logic              dneg_q,   dneg_d;  // dividend was negative (remainder sign)
  logic [XLEN-1:0]   result_q, result_d;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic accept;

  assign req_ready_o = ~rst & ~flush_i &
                       ((state_q == S_IDLE) | ((state_q == S_DONE) & resp_ready_i));
  assign accept      = req_valid_i & req_ready_o;

  assign resp_valid_o = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign result_o     = result_q;
  assign rd_o         = rd_q;

  // -------------------------------------------------------------------------
  // Request decode: signedness, magnitudes and the cases that skip CALC
  // -------------------------------------------------------------------------
  logic            a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, mul_zero, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign a_signed = (op_i == OP_MUL) | (op_i == OP_MULH) | (op_i == OP_MULHSU) |
                    (op_i == OP_DIV) | (op_i == OP_REM);
  assign b_signed = (op_i == OP_MUL) | (op_i == OP_MULH) |
                    (op_i == OP_DIV) | (op_i == OP_REM);
  assign a_neg    = a_signed & rs1_i[XLEN-1];
  assign b_neg    = b_signed & rs2_i[XLEN-1];
  assign a_mag    = cond_neg(rs1_i, a_neg);
  assign b_mag    = cond_neg(rs2_i, b_neg);

  assign div_zero = op_i[2] & (rs2_i == '0);
  // Only the signed divides (op_i[0] == 0) can overflow.
  assign div_ovf  = op_i[2] & ~op_i[0] & (rs1_i == XMIN) & (rs2_i == '1);

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_zero = ~op_i[2] & (b_mag == '0);
`else
  assign mul_zero = 1'b0;
`endif

  assign special = div_zero | div_ovf | mul_zero;

  // op_i[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
  // A zero multiplier yields zero, which is the default.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op_i[1] ? rs1_i : '1;
    end else if (div_ovf) begin
      special_res = op_i[1] ? '0 : rs1_i;
    end
  end

  // -------------------------------------------------------------------------
  // One CALC iteration of each datapath
  // -------------------------------------------------------------------------
  logic [2*XLEN-1:0] partial, acc_step, mcand_step, prod_fin;
  logic [XLEN-1:0]   mplier_step, mul_res;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   rem_step, quot_step, div_res;
  logic              mul_last;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) begin
        partial = partial + (mcand_q << i);
      end
    end
    acc_step    = acc_q + partial;
    mcand_step  = mcand_q << MUL_BITS_PER_CYCLE;
    mplier_step = mplier_q >> MUL_BITS_PER_CYCLE;
    prod_fin    = cond_neg_w(acc_step, neg_q);
    mul_res     = (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = (cnt_q == MUL_LAST) | (mplier_step == '0);
`else
  assign mul_last = (cnt_q == MUL_LAST);
`endif

  // Restoring step: shift the next dividend bit into the remainder and keep
  // the subtraction only if it did not borrow.
  always_comb begin
    div_shift = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q[XLEN-1:0]};
    if (div_diff[XLEN]) begin
      rem_step  = div_shift[XLEN-1:0];
      quot_step = {mplier_q[XLEN-2:0], 1'b0};
    end else begin
      rem_step  = div_diff[XLEN-1:0];
      quot_step = {mplier_q[XLEN-2:0], 1'b1};
    end
    div_res = op_q[1] ? cond_neg(rem_step, dneg_q) : cond_neg(quot_step, neg_q);
  end

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    dneg_d   = dneg_q;
    result_d = result_q;

    case (state_q)
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[2]) begin
          acc_d    = {{XLEN{1'b0}}, rem_step};
          mplier_d = quot_step;
          if (cnt_q == DIV_LAST) begin
            state_d  = S_DONE;
            result_d = div_res;
          end
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_step;
          mplier_d = mplier_step;
          if (mul_last) begin
            state_d  = S_DONE;
            result_d = mul_res;
          end
        end
      end
      S_DONE: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // An accept in DONE overrides the return to IDLE so issue is bubble-free.
    if (accept) begin
      op_d   = op_i;
      rd_d   = rd_i;
      cnt_d  = '0;
      acc_d  = '0;
      neg_d  = a_neg ^ b_neg;
      dneg_d = a_neg;
      if (op_i[2]) begin
        mcand_d  = {{XLEN{1'b0}}, b_mag};
        mplier_d = a_mag;
      end else begin
        mcand_d  = {{XLEN{1'b0}}, a_mag};
        mplier_d = b_mag;
      end
      if (special) begin
        state_d  = S_DONE;
        result_d = special_res;
      end else begin
        state_d  = S_CALC;
      end
    end

    if (flush_i) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      dneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      dneg_q   <= dneg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Self-checking bench for ex_muldiv_unit at XLEN=32, MUL_BITS_PER_CYCLE=4.
// Expected results come from a reference model using plain 64-bit integer
// arithmetic; expected latencies come from the operation class.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(
    .XLEN              (32),
    .MUL_BITS_PER_CYCLE(4),
    .RD_W              (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .op_i        (op_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .rd_i        (rd_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .result_o    (result_o),
    .rd_o        (rd_o),
    .busy_o      (busy_o)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_res(input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cycle offset (accept cycle = 0) at which resp_valid_o is first high.
  function automatic int ref_lat(input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] m;
    int n;
`endif
    if (op[2]) begin
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 33;
    end
`ifdef MULDIV_EARLY_OUT_EN
    m = ((op == 3'd0 || op == 3'd1) && b[31]) ? (32'd0 - b) : b;
    if (m == 32'd0) return 1;
    n = 0;
    while (m != 32'd0) begin m = m >> 4; n++; end
    return n + 1;
`else
    return 9;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 20));
      2:       return 32'd0 - 32'($urandom_range(1, 20));
      3:       return 32'h80000000;
      4:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus helper ----------------
  // Issues one op from IDLE, waits (bounded) for the response, takes it.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res,
                       output logic [4:0] rdo, output int lat);
    @(negedge clk);
    op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    req_valid_i = 1'b1; resp_ready_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
    rdo = rd_o;
    @(negedge clk); resp_ready_i = 1'b1;
    @(posedge clk); #1; resp_ready_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; req_valid_i = 1'b1; resp_ready_i = 1'b0;
    op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd3; rd_i = 5'd1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid_o); end
    total++; if (result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
    total++; if (rd_o !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d want=0", rd_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready_o); end
    @(negedge clk); req_valid_i = 1'b0; rst = 1'b0; #1;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", req_ready_o); end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5,
                             3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as [14] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                             32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
    logic [31:0] bs [14] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] exp_r [14] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF,
                                32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0,
                                32'hFFFFFFFF, 32'd5};
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    for (int i = 0; i < 14; i++) begin
      do_op(ops[i], as[i], bs[i], 5'(i + 1), res, rdo, lat);
      total++; if (res !== exp_r[i]) begin bad++; $display("FAIL directed_result[%0d] op=%0d got=%h want=%h", i, ops[i], res, exp_r[i]); end
      total++; if (rdo !== 5'(i + 1)) begin bad++; $display("FAIL directed_rd[%0d] got=%0d want=%0d", i, rdo, i + 1); end
      total++; if (lat != ref_lat(ops[i], as[i], bs[i])) begin bad++; $display("FAIL directed_latency[%0d] op=%0d got=%0d want=%0d", i, ops[i], lat, ref_lat(ops[i], as[i], bs[i])); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, want;
    logic [4:0]  rd, rdo;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      rd = 5'($urandom_range(0, 31));
      want = ref_res(op, a, b);
      do_op(op, a, b, rd, res, rdo, lat);
      total++; if (res !== want) begin bad++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, res, want); end
      total++; if (rdo !== rd) begin bad++; $display("FAIL random_rd[%0d] got=%0d want=%0d", i, rdo, rd); end
      total++; if (lat != ref_lat(op, a, b)) begin bad++; $display("FAIL random_latency[%0d] op=%0d a=%h b=%h got=%0d want=%0d", i, op, a, b, lat, ref_lat(op, a, b)); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    op_i = 3'd0; rs1_i = 32'd7; rs2_i = 32'hFFFFFFFD; rd_i = 5'd9;
    req_valid_i = 1'b1; resp_ready_i = 1'b0;
    @(posedge clk); #1; req_valid_i = 1'b0;
    lat = 1;
    while (!resp_valid_o && lat < 200) begin @(posedge clk); #1; lat++; end
    total++; if (resp_valid_o !== 1'b1) begin bad++; $display("FAIL hold_first_response got=%b want=1", resp_valid_o); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid_o !== 1'b1 || result_o !== 32'hFFFFFFEB || rd_o !== 5'd9) begin
        bad++; $display("FAIL hold_stable[%0d] valid=%b result=%h rd=%0d want 1/ffffffeb/9", c, resp_valid_o, result_o, rd_o);
      end
      total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL hold_req_ready[%0d] got=%b want=0", c, req_ready_o); end
    end
    @(negedge clk);
    resp_ready_i = 1'b1; req_valid_i = 1'b1;
    op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd3;
    #1;
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL chain_req_ready got=%b want=1", req_ready_o); end
    @(posedge clk); #1;
    req_valid_i = 1'b0; resp_ready_i = 1'b0;
    total++; if (resp_valid_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL chain_accept valid=%b busy=%b want 0/1", resp_valid_o, busy_o); end
    lat = 1;
    while (!resp_valid_o && lat < 200) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 33) begin bad++; $display("FAIL chain_latency got=%0d want=33", lat); end
    total++; if (result_o !== 32'd14) begin bad++; $display("FAIL chain_result got=%h want=0000000e", result_o); end
    total++; if (rd_o !== 5'd3) begin bad++; $display("FAIL chain_rd got=%0d want=3", rd_o); end
    @(negedge clk); resp_ready_i = 1'b1;
    @(posedge clk); #1; resp_ready_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL chain_idle busy=%b want=0", busy_o); end
  endtask

  task automatic test_flush();
    bit seen;
    @(negedge clk);
    op_i = 3'd4; rs1_i = 32'd0 - 32'd100; rs2_i = 32'd7; rd_i = 5'd4;
    req_valid_i = 1'b1; resp_ready_i = 1'b1;
    @(posedge clk); #1; req_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    flush_i = 1'b1; req_valid_i = 1'b1;
    op_i = 3'd0; rs1_i = 32'd5; rs2_i = 32'd5; rd_i = 5'd6;
    #1;
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL flush_req_ready got=%b want=0", req_ready_o); end
    @(posedge clk); #1;
    flush_i = 1'b0; req_valid_i = 1'b0;
    total++; if (busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin bad++; $display("FAIL flush_abort busy=%b valid=%b want 0/0", busy_o, resp_valid_o); end
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL flush_no_response seen=%b want=0", seen); end
    resp_ready_i = 1'b0;
  endtask

  task automatic test_rst_mid_calc();
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat;
    bit          seen;
    do_op(3'd0, 32'h1234, 32'd3, 5'd7, res, rdo, lat);
    total++; if (res !== 32'h369C) begin bad++; $display("FAIL mul_1234x3 got=%h want=0000369c", res); end
    total++; if (lat != ref_lat(3'd0, 32'h1234, 32'd3)) begin bad++; $display("FAIL mul_1234x3_latency got=%0d want=%0d", lat, ref_lat(3'd0, 32'h1234, 32'd3)); end
`ifdef MULDIV_EARLY_OUT_EN
    total++; if (lat >= 9) begin bad++; $display("FAIL early_out_latency got=%0d want<9", lat); end
`endif
    @(negedge clk);
    op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd12;
    req_valid_i = 1'b1;
    @(posedge clk); #1; req_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_mid_req_ready got=%b want=0", req_ready_o); end
    @(posedge clk); #1;
    total++;
    if (resp_valid_o !== 1'b0 || result_o !== 32'd0 || rd_o !== 5'd0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid_outputs valid=%b result=%h rd=%0d busy=%b want all 0", resp_valid_o, result_o, rd_o, busy_o);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid_o !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rst_mid_no_response seen=%b want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_rst_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
